// File: rtl/ace_aw_snoop_issuer.sv
// ACE AW snoop issuer: accepts one decoded AW, snoops all other masters over AC/CR,
// then forwards the AW with the merged snoop response. Optional timeout: ACE_SNOOP_TIMEOUT_EN.
package ace_aw_snoop_issuer_pkg;

    typedef struct packed {
        logic [7:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [2:0]  prot;
    } aw_chan_t;

endpackage

module ace_aw_snoop_issuer #(
    parameter int unsigned NumSnoopers   = 2,
    parameter type         aw_chan_t     = ace_aw_snoop_issuer_pkg::aw_chan_t,
    parameter int unsigned AddrWidth     = 64,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  aw_chan_t                                               aw_i,
    input  logic                                                   aw_valid_i,
    output logic                                                   aw_ready_o,
    input  logic [3:0]                                             acsnoop_i,
    input  logic                                                   snooping_i,
    input  logic                                                   illegal_i,
    input  logic [(NumSnoopers > 1 ? $clog2(NumSnoopers) : 1)-1:0] src_i,
    output logic [NumSnoopers-1:0]                                 ac_valid_o,
    input  logic [NumSnoopers-1:0]                                 ac_ready_i,
    output logic [AddrWidth-1:0]                                   ac_addr_o,
    output logic [3:0]                                             ac_snoop_o,
    output logic [2:0]                                             ac_prot_o,
    input  logic [NumSnoopers-1:0]                                 cr_valid_i,
    output logic [NumSnoopers-1:0]                                 cr_ready_o,
    input  logic [5*NumSnoopers-1:0]                               cr_resp_i,
    output aw_chan_t                                               aw_o,
    output logic                                                   aw_valid_o,
    input  logic                                                   aw_ready_i,
    output logic [4:0]                                             snoop_resp_o,
    output logic                                                   err_valid_o,
    input  logic                                                   err_ready_i
);

    localparam int unsigned SrcW  = (NumSnoopers > 1) ? $clog2(NumSnoopers) : 1;
    localparam int unsigned RespW = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SNOOP = 2'd1,
        FWD   = 2'd2,
        ERR   = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    aw_chan_t                 aw_q, aw_d;
    logic [3:0]               snoop_q, snoop_d;
    logic [NumSnoopers-1:0]   target_q, target_d;
    logic [NumSnoopers-1:0]   acc_q, acc_d;
    logic [NumSnoopers-1:0]   rsp_q, rsp_d;
    logic [RespW-1:0]         resp_q, resp_d;

    logic                     aw_ready_q, aw_ready_d;
    logic [NumSnoopers-1:0]   ac_valid_q, ac_valid_d;
    logic [NumSnoopers-1:0]   cr_ready_q, cr_ready_d;
    logic                     aw_valid_q, aw_valid_d;
    logic [RespW-1:0]         snoop_resp_q, snoop_resp_d;
    logic                     err_valid_q, err_valid_d;

    logic [NumSnoopers-1:0]   hs_ac;
    logic [NumSnoopers-1:0]   hs_cr;
    logic [NumSnoopers-1:0]   tgt_new;
    logic [RespW-1:0]         cr_or;
    logic                     timeout_hit;

    assign hs_ac = ac_valid_q & ac_ready_i;
    assign hs_cr = cr_ready_q & cr_valid_i;

    // Snoop targets: every master except the initiator; merged response of this cycle's CRs
    always_comb begin
        tgt_new = '0;
        cr_or   = '0;
        for (int unsigned i = 0; i < NumSnoopers; i++) begin
            tgt_new[i] = (SrcW'(i) != src_i);
            if (hs_cr[i]) begin
                cr_or = cr_or | cr_resp_i[RespW*i +: RespW];
            end
        end
    end

`ifdef ACE_SNOOP_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;

    // Counts SNOOP cycles; held at zero outside SNOOP so it starts fresh on entry
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != SNOOP)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign timeout_hit = (state_q == SNOOP) && (cnt_q == CntW'(TimeoutCycles - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        aw_d         = aw_q;
        snoop_d      = snoop_q;
        target_d     = target_q;
        acc_d        = acc_q;
        rsp_d        = rsp_q;
        resp_d       = resp_q;
        aw_ready_d   = 1'b0;
        ac_valid_d   = '0;
        cr_ready_d   = '0;
        aw_valid_d   = 1'b0;
        snoop_resp_d = '0;
        err_valid_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (aw_valid_i && aw_ready_q) begin
                    aw_d    = aw_i;
                    snoop_d = acsnoop_i;
                    if (illegal_i) begin
                        state_d     = ERR;
                        err_valid_d = 1'b1;
                    end else if (snooping_i && (tgt_new != '0)) begin
                        state_d    = SNOOP;
                        target_d   = tgt_new;
                        ac_valid_d = tgt_new;
                        cr_ready_d = tgt_new;
                    end else begin
                        state_d    = FWD;
                        aw_valid_d = 1'b1;
                    end
                end else begin
                    aw_ready_d = 1'b1;
                end
            end

            SNOOP: begin
                acc_d  = acc_q | hs_ac;
                rsp_d  = rsp_q | hs_cr;
                resp_d = resp_q | cr_or;
                // Completion beats a timeout landing in the same cycle
                if ((acc_d == target_q) && (rsp_d == target_q)) begin
                    state_d      = FWD;
                    aw_valid_d   = 1'b1;
                    snoop_resp_d = resp_d;
                end else if (timeout_hit) begin
                    state_d     = ERR;
                    err_valid_d = 1'b1;
                    target_d    = '0;
                    acc_d       = '0;
                    rsp_d       = '0;
                    resp_d      = '0;
                end else begin
                    ac_valid_d = target_q & ~acc_d;
                    cr_ready_d = target_q & ~rsp_d;
                end
            end

            FWD: begin
                if (aw_valid_q && aw_ready_i) begin
                    state_d    = IDLE;
                    aw_ready_d = 1'b1;
                    target_d   = '0;
                    acc_d      = '0;
                    rsp_d      = '0;
                    resp_d     = '0;
                end else begin
                    aw_valid_d   = 1'b1;
                    snoop_resp_d = snoop_resp_q;
                end
            end

            ERR: begin
                if (err_valid_q && err_ready_i) begin
                    state_d    = IDLE;
                    aw_ready_d = 1'b1;
                    target_d   = '0;
                    acc_d      = '0;
                    rsp_d      = '0;
                    resp_d     = '0;
                end else begin
                    err_valid_d = 1'b1;
                end
            end

            default: begin
                state_d    = IDLE;
                aw_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            aw_q         <= '0;
            snoop_q      <= '0;
            target_q     <= '0;
            acc_q        <= '0;
            rsp_q        <= '0;
            resp_q       <= '0;
            aw_ready_q   <= 1'b1;
            ac_valid_q   <= '0;
            cr_ready_q   <= '0;
            aw_valid_q   <= 1'b0;
            snoop_resp_q <= '0;
            err_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            aw_q         <= aw_d;
            snoop_q      <= snoop_d;
            target_q     <= target_d;
            acc_q        <= acc_d;
            rsp_q        <= rsp_d;
            resp_q       <= resp_d;
            aw_ready_q   <= aw_ready_d;
            ac_valid_q   <= ac_valid_d;
            cr_ready_q   <= cr_ready_d;
            aw_valid_q   <= aw_valid_d;
            snoop_resp_q <= snoop_resp_d;
            err_valid_q  <= err_valid_d;
        end
    end

    assign aw_ready_o   = aw_ready_q;
    assign ac_valid_o   = ac_valid_q;
    assign cr_ready_o   = cr_ready_q;
    assign ac_addr_o    = AddrWidth'(aw_q.addr);
    assign ac_snoop_o   = snoop_q;
    assign ac_prot_o    = 3'(aw_q.prot);
    assign aw_o         = aw_q;
    assign aw_valid_o   = aw_valid_q;
    assign snoop_resp_o = snoop_resp_q;
    assign err_valid_o  = err_valid_q;

endmodule

// File: tb/tb_ace_aw_snoop_issuer.sv
// Directed self-checking bench for ace_aw_snoop_issuer (2- and 3-snooper instances).
module tb_ace_aw_snoop_issuer;
    import ace_aw_snoop_issuer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    aw_chan_t   aw_in;
    logic [3:0] acsnoop;
    logic       snooping;
    logic       illegal;
    logic       dn_ready;
    logic       err_ready;

    // 2-snooper instance
    logic        d2_aw_valid, d2_aw_ready;
    logic [0:0]  d2_src;
    logic [1:0]  d2_ac_valid, d2_ac_ready, d2_cr_valid, d2_cr_ready;
    logic [63:0] d2_ac_addr;
    logic [3:0]  d2_ac_snoop;
    logic [2:0]  d2_ac_prot;
    logic [9:0]  d2_cr_resp;
    aw_chan_t    d2_aw_out;
    logic        d2_aw_valid_o;
    logic [4:0]  d2_snoop_resp;
    logic        d2_err_valid;

    // 3-snooper instance
    logic        d3_aw_valid, d3_aw_ready;
    logic [1:0]  d3_src;
    logic [2:0]  d3_ac_valid, d3_ac_ready, d3_cr_valid, d3_cr_ready;
    logic [63:0] d3_ac_addr;
    logic [3:0]  d3_ac_snoop;
    logic [2:0]  d3_ac_prot;
    logic [14:0] d3_cr_resp;
    aw_chan_t    d3_aw_out;
    logic        d3_aw_valid_o;
    logic [4:0]  d3_snoop_resp;
    logic        d3_err_valid;

    ace_aw_snoop_issuer #(.NumSnoopers(2), .AddrWidth(64), .TimeoutCycles(8)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .aw_i(aw_in), .aw_valid_i(d2_aw_valid), .aw_ready_o(d2_aw_ready),
        .acsnoop_i(acsnoop), .snooping_i(snooping), .illegal_i(illegal), .src_i(d2_src),
        .ac_valid_o(d2_ac_valid), .ac_ready_i(d2_ac_ready), .ac_addr_o(d2_ac_addr),
        .ac_snoop_o(d2_ac_snoop), .ac_prot_o(d2_ac_prot), .cr_valid_i(d2_cr_valid),
        .cr_ready_o(d2_cr_ready), .cr_resp_i(d2_cr_resp), .aw_o(d2_aw_out),
        .aw_valid_o(d2_aw_valid_o), .aw_ready_i(dn_ready), .snoop_resp_o(d2_snoop_resp),
        .err_valid_o(d2_err_valid), .err_ready_i(err_ready)
    );

    ace_aw_snoop_issuer #(.NumSnoopers(3), .AddrWidth(64), .TimeoutCycles(1024)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .aw_i(aw_in), .aw_valid_i(d3_aw_valid), .aw_ready_o(d3_aw_ready),
        .acsnoop_i(acsnoop), .snooping_i(snooping), .illegal_i(illegal), .src_i(d3_src),
        .ac_valid_o(d3_ac_valid), .ac_ready_i(d3_ac_ready), .ac_addr_o(d3_ac_addr),
        .ac_snoop_o(d3_ac_snoop), .ac_prot_o(d3_ac_prot), .cr_valid_i(d3_cr_valid),
        .cr_ready_o(d3_cr_ready), .cr_resp_i(d3_cr_resp), .aw_o(d3_aw_out),
        .aw_valid_o(d3_aw_valid_o), .aw_ready_i(dn_ready), .snoop_resp_o(d3_snoop_resp),
        .err_valid_o(d3_err_valid), .err_ready_i(err_ready)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_d2_idle(input string tag);
        check_eq({tag, ".aw_ready"},   64'(d2_aw_ready), 64'd1);
        check_eq({tag, ".aw_valid"},   64'(d2_aw_valid_o), 64'd0);
        check_eq({tag, ".ac_valid"},   64'(d2_ac_valid), 64'd0);
        check_eq({tag, ".cr_ready"},   64'(d2_cr_ready), 64'd0);
        check_eq({tag, ".err_valid"},  64'(d2_err_valid), 64'd0);
        check_eq({tag, ".snoop_resp"}, 64'(d2_snoop_resp), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; aw_in = '0; acsnoop = '0; snooping = 1'b0; illegal = 1'b0;
        dn_ready = 1'b0; err_ready = 1'b0;
        d2_aw_valid = 1'b0; d2_src = '0; d2_ac_ready = '0; d2_cr_valid = '0; d2_cr_resp = '0;
        d3_aw_valid = 1'b0; d3_src = '0; d3_ac_ready = '0; d3_cr_valid = '0; d3_cr_resp = '0;
        tick();
        tick();
        rst = 1'b0;
        check_d2_idle("reset");
        check_eq("reset.ac_addr", d2_ac_addr, 64'd0);
        check_eq("reset.d3_aw_ready", 64'(d3_aw_ready), 64'd1);
        check_eq("reset.d3_ac_valid", 64'(d3_ac_valid), 64'd0);

        // Snooping CleanInvalid from master 0, everything ready at once
        aw_in = '0; aw_in.addr = 64'h1000; aw_in.prot = 3'b010;
        acsnoop = 4'b1001; snooping = 1'b1; illegal = 1'b0; d2_src = 1'b0;
        d2_ac_ready = 2'b11; d2_cr_valid = 2'b10; d2_cr_resp = {5'b00100, 5'b00000};
        dn_ready = 1'b1; d2_aw_valid = 1'b1;
        tick();
        d2_aw_valid = 1'b0;
        check_eq("t1.ac_valid", 64'(d2_ac_valid), 64'b10);
        check_eq("t1.cr_ready", 64'(d2_cr_ready), 64'b10);
        check_eq("t1.aw_ready", 64'(d2_aw_ready), 64'd0);
        check_eq("t1.ac_addr",  d2_ac_addr, 64'h1000);
        check_eq("t1.ac_snoop", 64'(d2_ac_snoop), 64'h9);
        check_eq("t1.ac_prot",  64'(d2_ac_prot), 64'h2);
        check_eq("t1.aw_valid_c1", 64'(d2_aw_valid_o), 64'd0);
        tick();
        d2_cr_valid = '0;
        check_eq("t1.aw_valid_c2", 64'(d2_aw_valid_o), 64'd1);
        check_eq("t1.snoop_resp", 64'(d2_snoop_resp), 64'b00100);
        check_eq("t1.aw_addr", d2_aw_out.addr, 64'h1000);
        check_eq("t1.ac_valid_c2", 64'(d2_ac_valid), 64'd0);
        tick();
        check_d2_idle("t1.done");

        // Non-snooping write with downstream stalled three cycles
        aw_in.addr = 64'h2040; snooping = 1'b0; illegal = 1'b0; dn_ready = 1'b0;
        d2_aw_valid = 1'b1;
        tick();
        d2_aw_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check_eq($sformatf("t2.aw_valid_c%0d", c), 64'(d2_aw_valid_o), 64'd1);
            check_eq($sformatf("t2.aw_ready_c%0d", c), 64'(d2_aw_ready), 64'd0);
            check_eq($sformatf("t2.ac_valid_c%0d", c), 64'(d2_ac_valid), 64'd0);
            check_eq($sformatf("t2.addr_c%0d", c), d2_aw_out.addr, 64'h2040);
            check_eq($sformatf("t2.resp_c%0d", c), 64'(d2_snoop_resp), 64'd0);
            tick();
        end
        dn_ready = 1'b1;
        check_eq("t2.aw_valid_c4", 64'(d2_aw_valid_o), 64'd1);
        tick();
        check_d2_idle("t2.done");

        // Illegal write (also flagged snooping): error report only
        illegal = 1'b1; snooping = 1'b1; err_ready = 1'b0; d2_aw_valid = 1'b1;
        tick();
        d2_aw_valid = 1'b0; illegal = 1'b0;
        check_eq("t3.err_c1", 64'(d2_err_valid), 64'd1);
        check_eq("t3.ac_c1",  64'(d2_ac_valid), 64'd0);
        check_eq("t3.aw_c1",  64'(d2_aw_valid_o), 64'd0);
        tick();
        check_eq("t3.err_c2", 64'(d2_err_valid), 64'd1);
        check_eq("t3.aw_rdy_c2", 64'(d2_aw_ready), 64'd0);
        err_ready = 1'b1;
        tick();
        err_ready = 1'b0;
        check_d2_idle("t3.done");

        // Initiator 1: CR from master 0 arrives before its AC handshake
        snooping = 1'b1; d2_src = 1'b1; d2_ac_ready = 2'b00; aw_in.addr = 64'h3000;
        d2_aw_valid = 1'b1;
        tick();
        d2_aw_valid = 1'b0;
        check_eq("t5.ac_valid_c1", 64'(d2_ac_valid), 64'b01);
        d2_cr_valid = 2'b01; d2_cr_resp = {5'b00000, 5'b10000};
        tick();
        d2_cr_valid = '0;
        check_eq("t5.ac_valid_c2", 64'(d2_ac_valid), 64'b01);
        check_eq("t5.cr_ready_c2", 64'(d2_cr_ready), 64'b00);
        d2_ac_ready = 2'b01;
        tick();
        d2_ac_ready = 2'b00;
        check_eq("t5.aw_valid", 64'(d2_aw_valid_o), 64'd1);
        check_eq("t5.resp", 64'(d2_snoop_resp), 64'b10000);
        tick();
        check_d2_idle("t5.done");

        // Three snoopers, initiator 2: staggered AC/CR handshakes
        snooping = 1'b1; d3_src = 2'd2; d3_ac_ready = 3'b000; aw_in.addr = 64'h4000;
        d3_aw_valid = 1'b1;
        tick();
        d3_aw_valid = 1'b0;
        check_eq("t4.ac_valid_c1", 64'(d3_ac_valid), 64'b011);
        d3_ac_ready = 3'b001;
        tick();
        d3_ac_ready = 3'b000;
        check_eq("t4.ac_valid_c2", 64'(d3_ac_valid), 64'b010);
        tick();
        check_eq("t4.ac_valid_c3", 64'(d3_ac_valid), 64'b010);
        tick();
        check_eq("t4.ac_valid_c4", 64'(d3_ac_valid), 64'b010);
        d3_ac_ready = 3'b010; d3_cr_valid = 3'b010; d3_cr_resp = {5'b0, 5'b01000, 5'b0};
        tick();
        d3_ac_ready = 3'b000; d3_cr_valid = 3'b000;
        check_eq("t4.ac_valid_c5", 64'(d3_ac_valid), 64'b000);
        check_eq("t4.cr_ready_c5", 64'(d3_cr_ready), 64'b001);
        tick();
        check_eq("t4.aw_valid_c6", 64'(d3_aw_valid_o), 64'd0);
        d3_cr_valid = 3'b001; d3_cr_resp = {5'b0, 5'b0, 5'b00011};
        tick();
        d3_cr_valid = 3'b000;
        check_eq("t4.aw_valid_c7", 64'(d3_aw_valid_o), 64'd1);
        check_eq("t4.resp_c7", 64'(d3_snoop_resp), 64'b01011);
        check_eq("t4.addr_c7", d3_aw_out.addr, 64'h4000);
        tick();
        check_eq("t4.aw_ready_done", 64'(d3_aw_ready), 64'd1);
        check_eq("t4.aw_valid_done", 64'(d3_aw_valid_o), 64'd0);

`ifdef ACE_SNOOP_TIMEOUT_EN
        // No snooper ever answers: timeout after eight SNOOP cycles
        snooping = 1'b1; d2_src = 1'b0; d2_ac_ready = 2'b00; d2_cr_valid = 2'b00;
        d2_aw_valid = 1'b1;
        tick();
        d2_aw_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check_eq($sformatf("to.err_c%0d", c), 64'(d2_err_valid), 64'd0);
            check_eq($sformatf("to.aw_c%0d", c), 64'(d2_aw_valid_o), 64'd0);
            check_eq($sformatf("to.ac_c%0d", c), 64'(d2_ac_valid), 64'b10);
            tick();
        end
        check_eq("to.err_c9", 64'(d2_err_valid), 64'd1);
        check_eq("to.ac_c9", 64'(d2_ac_valid), 64'd0);
        check_eq("to.cr_c9", 64'(d2_cr_ready), 64'd0);
        check_eq("to.aw_c9", 64'(d2_aw_valid_o), 64'd0);
        err_ready = 1'b1;
        tick();
        err_ready = 1'b0;
        check_d2_idle("to.done");
`endif

        // Reset while snooping discards the transaction
        snooping = 1'b1; d2_src = 1'b0; d2_ac_ready = 2'b00; d2_cr_valid = 2'b00;
        aw_in.addr = 64'h5000; d2_aw_valid = 1'b1;
        tick();
        d2_aw_valid = 1'b0;
        check_eq("rs.ac_valid_pre", 64'(d2_ac_valid), 64'b10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_d2_idle("rs");
        check_eq("rs.ac_addr", d2_ac_addr, 64'd0);
        check_eq("rs.aw_addr", d2_aw_out.addr, 64'd0);
        check_eq("rs.ac_snoop", 64'(d2_ac_snoop), 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
